// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for a PWM generator: mirrors the PWM period counter and
// walks the duty toward a configured target one step per STEP_DIV periods.
module pwm_ramp_ctrl #(
  parameter int W          = 16,
  parameter int DEF_PERIOD = 1000,
  parameter int STEP_DIV   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         estop,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic [W-1:0] cfg_target,
  input  logic [W-1:0] cfg_step,
  output logic [W-1:0] pwm_period,
  output logic [W-1:0] pwm_duty,
  output logic         period_tick,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, RAMP, HOLD, RAMPDN, STOP} state_t;

  state_t state, state_nxt;

  logic [W-1:0] cnt, cnt_last;
  logic [W-1:0] div, div_nxt;
  logic [W-1:0] tgt, step;
  logic [W-1:0] sh_period, sh_tgt, sh_step;
  logic         pend;
  logic [W-1:0] duty_nxt;
  logic         done_nxt;
  logic [W-1:0] goal, stepped;
  logic [W-1:0] cfg_period_eff;
  logic         accept, apply, div_hit, moving;

  // Saturating step up: W+1-bit sum so a large step cannot wrap past the goal.
  function automatic logic [W-1:0] sat_up(input logic [W-1:0] cur, input logic [W-1:0] st,
                                          input logic [W-1:0] lim);
    logic [W:0] sum;
    sum = {1'b0, cur} + {1'b0, st};
    return (sum > {1'b0, lim}) ? lim : sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_down(input logic [W-1:0] cur, input logic [W-1:0] st,
                                            input logic [W-1:0] lim);
    return ((cur - lim) <= st) ? lim : cur - st;
  endfunction

  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] st,
                                               input logic [W-1:0] lim);
    if (st == '0 || cur == lim) return lim;
    if (cur < lim) return sat_up(cur, st, lim);
    return sat_down(cur, st, lim);
  endfunction

  assign cnt_last    = (pwm_period == '0) ? '0 : pwm_period - W'(1);
  assign period_tick = (cnt == cnt_last);

  // An offer coinciding with estop is refused so nothing can become pending during a stop.
  assign cfg_ready = (state != STOP) && !estop;
  assign busy      = (state == RAMP) || (state == RAMPDN);

  assign accept         = cfg_valid && cfg_ready;
  assign apply          = period_tick && pend && (state != STOP);
  assign div_hit        = (div == W'(STEP_DIV - 1));
  assign moving         = (state == RAMP) || (state == RAMPDN);
  assign goal           = (state == RAMPDN) ? '0 : tgt;
  assign stepped        = step_toward(pwm_duty, step, goal);
  assign cfg_period_eff = (cfg_period == '0) ? W'(1) : cfg_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = pwm_duty;
    div_nxt   = div;
    done_nxt  = 1'b0;
    if (estop) begin
      state_nxt = STOP;
      duty_nxt  = '0;
      div_nxt   = '0;
    end else if (state == STOP) begin
      state_nxt = IDLE;
    end else if (apply) begin
      div_nxt = '0;
      if (enable)                               state_nxt = RAMP;
      else if (state == RAMP || state == HOLD)  state_nxt = RAMPDN;
    end else if (!enable && (state == RAMP || state == HOLD)) begin
      state_nxt = RAMPDN;
    end else if (enable && state == RAMPDN) begin
      state_nxt = RAMP;
    end else if (period_tick && moving) begin
      if (!div_hit) begin
        div_nxt = div + W'(1);
      end else begin
        div_nxt  = '0;
        duty_nxt = stepped;
        if (stepped == goal) begin
          if (state == RAMPDN || goal == '0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            done_nxt  = 1'b1;
          end
        end
      end
    end
  end

  // Registered datapath: period counter, shadow config, applied config and duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      div        <= '0;
      pwm_period <= W'(DEF_PERIOD);
      pwm_duty   <= '0;
      done       <= 1'b0;
      tgt        <= '0;
      step       <= '0;
      sh_period  <= '0;
      sh_tgt     <= '0;
      sh_step    <= '0;
      pend       <= 1'b0;
    end else begin
      cnt      <= period_tick ? '0 : cnt + W'(1);
      div      <= div_nxt;
      pwm_duty <= duty_nxt;
      done     <= done_nxt;
      if (apply && !estop) begin
        pwm_period <= sh_period;
        tgt        <= sh_tgt;
        step       <= sh_step;
      end
      if (accept) begin
        sh_period <= cfg_period;
        sh_tgt    <= (cfg_target > cfg_period_eff) ? cfg_period_eff : cfg_target;
        sh_step   <= cfg_step;
      end
      if (estop)       pend <= 1'b0;
      else if (accept) pend <= 1'b1;
      else if (apply)  pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: one instance with STEP_DIV=1, one with STEP_DIV=3,
// sharing clock, reset and inputs.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, estop = 1'b0, cfg_valid = 1'b0;
  logic [15:0] cfg_period = '0, cfg_target = '0, cfg_step = '0;

  logic        cfg_ready, period_tick, busy, done;
  logic [15:0] pwm_period, pwm_duty;
  logic        cfg_ready2, period_tick2, busy2, done2;
  logic [15:0] pwm_period2, pwm_duty2;

  int tests_run = 0;
  int failures  = 0;

  pwm_ramp_ctrl #(.W(16), .DEF_PERIOD(1000), .STEP_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .estop(estop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_period(cfg_period),
    .cfg_target(cfg_target), .cfg_step(cfg_step), .pwm_period(pwm_period),
    .pwm_duty(pwm_duty), .period_tick(period_tick), .busy(busy), .done(done)
  );

  pwm_ramp_ctrl #(.W(16), .DEF_PERIOD(1000), .STEP_DIV(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .estop(estop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2), .cfg_period(cfg_period),
    .cfg_target(cfg_target), .cfg_step(cfg_step), .pwm_period(pwm_period2),
    .pwm_duty(pwm_duty2), .period_tick(period_tick2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // Returns at the falling edge where the selected instance shows period_tick.
  task automatic wait_tick(input bit second, output int n);
    n = -1;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if ((second ? period_tick2 : period_tick) === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      tests_run++; failures++;
      $display("FAIL tick_timeout: no period_tick within 1100 cycles");
    end
  endtask

  task automatic offer(input logic [15:0] p, input logic [15:0] t, input logic [15:0] s);
    cfg_period = p; cfg_target = t; cfg_step = s; cfg_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; estop = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (pwm_period !== 16'd1000) begin failures++; $display("FAIL reset_period: got %0d expected 1000", pwm_period); end
    tests_run++; if (pwm_duty !== 16'd0) begin failures++; $display("FAIL reset_duty: got %0d expected 0", pwm_duty); end
    tests_run++; if ({period_tick, busy, done, cfg_ready} !== 4'b0001) begin failures++; $display("FAIL reset_flags: got %b expected 0001", {period_tick, busy, done, cfg_ready}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp_up();
    int n;
    logic [15:0] exp_d;
    enable = 1'b1;
    offer(16'd10, 16'd6, 16'd2);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_tick(1'b0, n);
    @(negedge clk);
    tests_run++; if (pwm_period !== 16'd10) begin failures++; $display("FAIL apply_period: got %0d expected 10", pwm_period); end
    tests_run++; if (pwm_duty !== 16'd0 || busy !== 1'b1) begin failures++; $display("FAIL apply_state: duty %0d busy %b expected duty 0 busy 1", pwm_duty, busy); end
    for (int k = 1; k <= 3; k++) begin
      exp_d = 16'(2 * k);
      wait_tick(1'b0, n);
      tests_run++; if (n != 9) begin failures++; $display("FAIL tick_spacing: got %0d cycles expected 9", n); end
      @(negedge clk);
      tests_run++; if (pwm_duty !== exp_d) begin failures++; $display("FAIL ramp_duty: got %0d expected %0d", pwm_duty, exp_d); end
      tests_run++; if (done !== (k == 3)) begin failures++; $display("FAIL ramp_done: got %b expected %b", done, (k == 3)); end
    end
    tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy: got %b expected 0", busy); end
    @(negedge clk);
    tests_run++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b expected 0", done); end
  endtask

  task automatic test_ramp_down();
    int n;
    logic [15:0] exp_d;
    enable = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b1 || pwm_duty !== 16'd6) begin failures++; $display("FAIL rampdn_enter: busy %b duty %0d expected busy 1 duty 6", busy, pwm_duty); end
    for (int k = 1; k <= 3; k++) begin
      exp_d = 16'(6 - 2 * k);
      wait_tick(1'b0, n);
      @(negedge clk);
      tests_run++; if (pwm_duty !== exp_d) begin failures++; $display("FAIL rampdn_duty: got %0d expected %0d", pwm_duty, exp_d); end
    end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rampdn_idle: busy %b done %b expected 0 0", busy, done); end
  endtask

  task automatic test_jump_clamp();
    int n;
    enable = 1'b1;
    offer(16'd10, 16'd15, 16'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_tick(1'b0, n);
    @(negedge clk);
    tests_run++; if (pwm_duty !== 16'd0 || busy !== 1'b1) begin failures++; $display("FAIL jump_apply: duty %0d busy %b expected 0 1", pwm_duty, busy); end
    wait_tick(1'b0, n);
    @(negedge clk);
    tests_run++; if (pwm_duty !== 16'd10) begin failures++; $display("FAIL jump_clamp_duty: got %0d expected 10", pwm_duty); end
    tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL jump_done: done %b busy %b expected 1 0", done, busy); end
  endtask

  task automatic test_estop();
    int n;
    enable = 1'b0;
    @(negedge clk);
    wait_tick(1'b0, n);
    @(negedge clk);
    tests_run++; if (pwm_duty !== 16'd0 || busy !== 1'b0) begin failures++; $display("FAIL jumpdown_idle: duty %0d busy %b expected 0 0", pwm_duty, busy); end
    enable = 1'b1;
    offer(16'd10, 16'd8, 16'd2);
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_tick(1'b0, n);
      @(negedge clk);
    end
    tests_run++; if (pwm_duty !== 16'd4 || busy !== 1'b1) begin failures++; $display("FAIL pre_estop: duty %0d busy %b expected 4 1", pwm_duty, busy); end
    estop = 1'b1;
    offer(16'd20, 16'd20, 16'd20);
    @(negedge clk);
    tests_run++; if (pwm_duty !== 16'd0) begin failures++; $display("FAIL estop_duty: got %0d expected 0", pwm_duty); end
    tests_run++; if (cfg_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL estop_ready: ready %b busy %b expected 0 0", cfg_ready, busy); end
    tests_run++; if (pwm_period !== 16'd10) begin failures++; $display("FAIL estop_period: got %0d expected 10", pwm_period); end
    @(negedge clk);
    cfg_valid = 1'b0;
    estop = 1'b0;
    @(negedge clk);
    tests_run++; if (cfg_ready !== 1'b1 || busy !== 1'b0 || pwm_duty !== 16'd0) begin failures++; $display("FAIL estop_release: ready %b busy %b duty %0d expected 1 0 0", cfg_ready, busy, pwm_duty); end
    wait_tick(1'b0, n);
    @(negedge clk);
    tests_run++; if (pwm_period !== 16'd10 || busy !== 1'b0) begin failures++; $display("FAIL estop_no_pending: period %0d busy %b expected 10 0", pwm_period, busy); end
  endtask

  task automatic test_mid_period_cfg();
    int n;
    repeat (3) @(negedge clk);
    offer(16'd12, 16'd5, 16'd5);
    @(negedge clk);
    offer(16'd8, 16'd3, 16'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    tests_run++; if (pwm_period !== 16'd10 || pwm_duty !== 16'd0) begin failures++; $display("FAIL midcfg_hold: period %0d duty %0d expected 10 0", pwm_period, pwm_duty); end
    wait_tick(1'b0, n);
    tests_run++; if (n != 4 || pwm_period !== 16'd10) begin failures++; $display("FAIL midcfg_tick: after %0d cycles period %0d expected 4 cycles period 10", n, pwm_period); end
    @(negedge clk);
    tests_run++; if (pwm_period !== 16'd8 || busy !== 1'b1) begin failures++; $display("FAIL last_cfg_wins_period: period %0d busy %b expected 8 1", pwm_period, busy); end
    wait_tick(1'b0, n);
    tests_run++; if (n != 7) begin failures++; $display("FAIL new_period_len: got %0d cycles expected 7", n); end
    @(negedge clk);
    tests_run++; if (pwm_duty !== 16'd3 || done !== 1'b1) begin failures++; $display("FAIL last_cfg_wins_duty: duty %0d done %b expected 3 1", pwm_duty, done); end
  endtask

  task automatic test_back_to_back();
    int n;
    wait_tick(1'b0, n);
    offer(16'd8, 16'd6, 16'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    tests_run++; if (pwm_duty !== 16'd3 || busy !== 1'b0) begin failures++; $display("FAIL accept_on_tick_defer: duty %0d busy %b expected 3 0", pwm_duty, busy); end
    wait_tick(1'b0, n);
    @(negedge clk);
    tests_run++; if (pwm_duty !== 16'd3 || busy !== 1'b1) begin failures++; $display("FAIL deferred_apply: duty %0d busy %b expected 3 1", pwm_duty, busy); end
    wait_tick(1'b0, n);
    @(negedge clk);
    tests_run++; if (pwm_duty !== 16'd6 || done !== 1'b1) begin failures++; $display("FAIL deferred_step: duty %0d done %b expected 6 1", pwm_duty, done); end
  endtask

  task automatic test_step_div();
    int n;
    logic [15:0] exp_d;
    rst_n = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    offer(16'd10, 16'd2, 16'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_tick(1'b1, n);
    @(negedge clk);
    tests_run++; if (pwm_period2 !== 16'd10 || busy2 !== 1'b1 || pwm_duty2 !== 16'd0) begin failures++; $display("FAIL div_apply: period %0d busy %b duty %0d expected 10 1 0", pwm_period2, busy2, pwm_duty2); end
    for (int k = 1; k <= 5; k++) begin
      exp_d = (k >= 3) ? 16'd1 : 16'd0;
      wait_tick(1'b1, n);
      @(negedge clk);
      tests_run++; if (pwm_duty2 !== exp_d) begin failures++; $display("FAIL div_duty tick %0d: got %0d expected %0d", k, pwm_duty2, exp_d); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++; if (pwm_duty2 !== 16'd0 || pwm_period2 !== 16'd1000 || busy2 !== 1'b0) begin failures++; $display("FAIL async_reset: duty %0d period %0d busy %b expected 0 1000 0", pwm_duty2, pwm_period2, busy2); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_jump_clamp();
    test_estop();
    test_mid_period_cfg();
    test_back_to_back();
    test_step_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
